// File: rtl/acc_mem_pkg.sv
// rtl/acc_mem_pkg.sv - shared types and default widths for the accumulator memory responder
package acc_mem_pkg;

  localparam int ACC_ADDR_W = 12;
  localparam int ACC_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/acc_mem_responder_if.sv
// rtl/acc_mem_responder_if.sv - CPU-to-memory request/ack bus; ACC_MEM_PARITY_EN adds inj_par/parity_err
interface acc_mem_responder_if
  import acc_mem_pkg::*;
#(
  parameter int ADDR_W = ACC_ADDR_W,
  parameter int DATA_W = ACC_DATA_W
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              req_err;
`ifdef ACC_MEM_PARITY_EN
  logic              inj_par;
  logic              parity_err;

  modport master (output mem_read, mem_write, addr, wdata, inj_par,
                  input  rdata, ack, busy, req_err, parity_err);
  modport slave  (input  mem_read, mem_write, addr, wdata, inj_par,
                  output rdata, ack, busy, req_err, parity_err);
`else
  modport master (output mem_read, mem_write, addr, wdata,
                  input  rdata, ack, busy, req_err);
  modport slave  (input  mem_read, mem_write, addr, wdata,
                  output rdata, ack, busy, req_err);
`endif
endinterface

// File: rtl/acc_mem_array.sv
// rtl/acc_mem_array.sv - single-port synchronous RAM; read port holds its value between reads
module acc_mem_array #(
  parameter int ADDR_W = 12,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  q
);
  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Only the output register resets; array contents survive reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             q <= '0;
    else if (en && !we)  q <= mem[addr];
  end
endmodule

// File: rtl/acc_mem_responder.sv
// rtl/acc_mem_responder.sv - wait-state memory responder for the multicycle CPU; option ACC_MEM_PARITY_EN
module acc_mem_responder
  import acc_mem_pkg::*;
#(
  parameter int ADDR_W      = ACC_ADDR_W,
  parameter int DATA_W      = ACC_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  acc_mem_responder_if.slave bus
);
`ifdef ACC_MEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

  state_t            state;
  op_t               op_q;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [RAM_W-1:0]  wdata_q;
  logic [RAM_W-1:0]  ram_q;
  logic              req_err_q;
  logic              commit;
  logic [RAM_W-1:0]  wword;

`ifdef ACC_MEM_PARITY_EN
  assign wword = {(^bus.wdata) ^ bus.inj_par, bus.wdata};
`else
  assign wword = bus.wdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_RD;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_err_q <= 1'b0;
    end else begin
      req_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_read ^ bus.mem_write) begin
            addr_q  <= bus.addr;
            wdata_q <= wword;
            op_q    <= bus.mem_write ? OP_WR : OP_RD;
            cnt     <= '0;
            state   <= WAIT;
          end else if (bus.mem_read && bus.mem_write) begin
            req_err_q <= 1'b1;
          end
        end
        // Compare before increment so the counter never wraps.
        WAIT: begin
          if (cnt == CNT_MAX) state <= RESP;
          else                cnt   <= cnt + 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign commit = (state == WAIT) && (cnt == CNT_MAX);

  acc_mem_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (RAM_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (commit),
    .we    (op_q == OP_WR),
    .addr  (addr_q),
    .wdata (wdata_q),
    .q     (ram_q)
  );

  assign bus.ack     = (state == RESP);
  assign bus.busy    = (state != IDLE);
  assign bus.req_err = req_err_q;
  assign bus.rdata   = ram_q[DATA_W-1:0];
`ifdef ACC_MEM_PARITY_EN
  // Stored words carry even parity, so a set XOR over the whole word is a mismatch.
  assign bus.parity_err = (state == RESP) && (op_q == OP_RD) && (^ram_q);
`endif
endmodule
